// File: rtl/cpu_pkg.sv
// Shared CPU package: datapath/register-file widths plus the encodings used by the
// iterative multiply/divide sequencer (op codes, alu_status codes, FSM state).
package cpu_pkg;

  // Datapath and register-file defaults
  localparam int unsigned CPU_WIDTH = 16;
  localparam int unsigned CPU_RD_W  = 4;

  // Multiply/divide op encodings. op[1] selects divide; op[0] selects the upper half
  // of the accumulator (MULH high product, REMU remainder).
  localparam logic [1:0] MD_MUL  = 2'b00;
  localparam logic [1:0] MD_MULH = 2'b01;
  localparam logic [1:0] MD_DIVU = 2'b10;
  localparam logic [1:0] MD_REMU = 2'b11;

  // alu_status codes seen by the hazard controller (stalls while > ST_DONE)
  localparam logic [1:0] ST_IDLE     = 2'b00;
  localparam logic [1:0] ST_DONE     = 2'b01;
  localparam logic [1:0] ST_BUSY_MUL = 2'b10;
  localparam logic [1:0] ST_BUSY_DIV = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StDone
  } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared multiply/divide datapath (purely combinational).
//   acc      in  2*WIDTH  accumulator {hi, lo}
//   operand  in  WIDTH    multiplicand (multiply) or divisor (divide)
//   is_div   in  1        0: shift-add multiply step, 1: restoring divide step
//   acc_next out 2*WIDTH  accumulator after this iteration
// Multiply: lo holds the unconsumed multiplier, hi the partial product.
// Divide:   hi holds the partial remainder, lo shifts dividend out / quotient in.
module muldiv_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  always_comb begin
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    // Remainder shifted left with the next dividend bit; needs WIDTH+1 bits.
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    borrow = rem_sh < {1'b0, operand};
    // Only used when no borrow, in which case the true difference fits in WIDTH bits.
    diff   = rem_sh[WIDTH-1:0] - operand;
    if (!is_div) begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end else if (!borrow) begin
      acc_next = {diff, acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide sequencer for the EX stage: one operation at a time,
// one bit per cycle, with alu_status driving the IF/ID + ID/EX stall.
//   clk, rst_n      clock, asynchronous active-low reset
//   start, op       launch (IDLE/DONE only); 00 MUL, 01 MULH, 10 DIVU, 11 REMU
//   src_a, src_b    multiplicand/dividend, multiplier/divisor
//   rd_in           destination register
//   flush           kill in-flight op; beats start
//   result, result_valid, result_rd   single-cycle writeback
//   busy_rd         destination of in-flight op (0 when none)
//   alu_status      00 idle, 01 done, 10 busy MUL, 11 busy DIV
// Optional build macro MULDIV_EARLY_OUT_EN: finish MUL as soon as the remaining
// multiplier bits are zero (results unchanged, latency shorter).
module muldiv_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = CPU_WIDTH,
  parameter int unsigned RD_W  = CPU_RD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [RD_W-1:0]  rd_in,
  input  logic             flush,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic [RD_W-1:0]  result_rd,
  output logic [RD_W-1:0]  busy_rd,
  output logic [1:0]       alu_status
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  md_state_e          state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [RD_W-1:0]    rd_q, rd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] mul_final;
  logic               mul_last;

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc      (acc_q),
    .operand  (opnd_q),
    .is_div   (op_q[1]),
    .acc_next (step_acc)
  );

`ifdef MULDIV_EARLY_OUT_EN
  // Multiplier bits still to be consumed after this step sit at lo[WIDTH-1-cnt:1].
  // Once they are zero the remaining iterations are pure shifts, done in one go.
  logic [WIDTH-1:0] mul_mask;
  logic [CNT_W-1:0] rem_cnt;
  assign mul_mask  = ({WIDTH{1'b1}} >> (cnt_q + CNT_W'(1))) << 1;
  assign rem_cnt   = LastCnt - cnt_q;
  assign mul_last  = (acc_q[WIDTH-1:0] & mul_mask) == '0;
  assign mul_final = step_acc >> rem_cnt;
`else
  assign mul_last  = (cnt_q == LastCnt);
  assign mul_final = step_acc;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      rd_q   <= '0;
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
    end else begin
      op_q   <= op_d;
      rd_q   <= rd_d;
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start && !flush) begin
          op_d  = op;
          rd_d  = rd_in;
          cnt_d = '0;
          if (!op[1]) begin
            state_d = StMul;
            acc_d   = {{WIDTH{1'b0}}, src_b};
            opnd_d  = src_a;
          end else if (src_b != '0) begin
            state_d = StDiv;
            acc_d   = {{WIDTH{1'b0}}, src_a};
            opnd_d  = src_b;
          end else begin
            // Divide by zero: quotient all ones, remainder = dividend.
            state_d = StDone;
            acc_d   = {src_a, {WIDTH{1'b1}}};
            opnd_d  = src_b;
          end
        end
      end
      StMul: begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = step_acc;
        if (mul_last) begin
          state_d = StDone;
          acc_d   = mul_final;
        end
      end
      StDiv: begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = step_acc;
        if (cnt_q == LastCnt) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d = StIdle;
    end
  end

  // Outputs decoded from state
  always_comb begin
    result       = '0;
    result_valid = 1'b0;
    result_rd    = '0;
    busy_rd      = '0;
    alu_status   = ST_IDLE;
    unique case (state_q)
      StMul: begin
        alu_status = ST_BUSY_MUL;
        busy_rd    = rd_q;
      end
      StDiv: begin
        alu_status = ST_BUSY_DIV;
        busy_rd    = rd_q;
      end
      StDone: begin
        alu_status   = ST_DONE;
        busy_rd      = rd_q;
        result_rd    = rd_q;
        result_valid = !flush;
        // MULH/REMU live in the upper half, MUL/DIVU in the lower half.
        result       = op_q[0] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer. Inputs change on the falling edge, outputs
// are sampled on the falling edge. Build with MULDIV_EARLY_OUT_EN to match that RTL.
module tb_muldiv_sequencer;
  import cpu_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned RW = 4;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int unsigned LatFf   = 10;
  localparam int unsigned LatFfff = 17;
  localparam int unsigned Lat3x4  = 4;
  localparam int unsigned Lat2x3  = 3;
  localparam int unsigned Lat9x1  = 2;
`else
  localparam int unsigned LatFf   = 17;
  localparam int unsigned LatFfff = 17;
  localparam int unsigned Lat3x4  = 17;
  localparam int unsigned Lat2x3  = 17;
  localparam int unsigned Lat9x1  = 17;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  src_a;
  logic [W-1:0]  src_b;
  logic [RW-1:0] rd_in;
  logic          flush;
  logic [W-1:0]  result;
  logic          result_valid;
  logic [RW-1:0] result_rd;
  logic [RW-1:0] busy_rd;
  logic [1:0]    alu_status;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  muldiv_sequencer #(
    .WIDTH (W),
    .RD_W  (RW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .op           (op),
    .src_a        (src_a),
    .src_b        (src_b),
    .rd_in        (rd_in),
    .flush        (flush),
    .result       (result),
    .result_valid (result_valid),
    .result_rd    (result_rd),
    .busy_rd      (busy_rd),
    .alu_status   (alu_status)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Present one start pulse; returns at the falling edge of the first cycle after start.
  task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [RW-1:0] rd);
    @(negedge clk);
    op = o; src_a = a; src_b = b; rd_in = rd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count cycles (start cycle = 0) until result_valid, checking the busy code meanwhile.
  task automatic run_to_done(input string tag, input logic [1:0] busy, output int lat);
    int bad;
    bad = 0;
    lat = 1;
    while (result_valid !== 1'b1 && lat < 40) begin
      if (alu_status !== busy) bad++;
      @(negedge clk);
      lat++;
    end
    check({tag, "_busy_status"}, bad, 0);
  endtask

  task automatic full_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [RW-1:0] rd,
                         input logic [W-1:0] exp_res, input int exp_lat);
    int lat;
    launch(o, a, b, rd);
    run_to_done(tag, o[1] ? ST_BUSY_DIV : ST_BUSY_MUL, lat);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_result_rd"}, result_rd, rd);
    check({tag, "_status_done"}, alu_status, ST_DONE);
    check({tag, "_busy_rd"}, busy_rd, rd);
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, "_idle_status"}, alu_status, ST_IDLE);
    check({tag, "_idle_valid"}, result_valid, 1'b0);
  endtask

  initial begin
    int lat;
    int bad;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    op = '0; src_a = '0; src_b = '0; rd_in = '0;
    #12;
    check("rst_result", result, 0);
    check("rst_valid", result_valid, 0);
    check("rst_result_rd", result_rd, 0);
    check("rst_busy_rd", busy_rd, 0);
    check("rst_status", alu_status, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;

    full_op("mul_ff", MD_MUL, 16'h00FF, 16'h0101, 4'd3, 16'hFFFF, LatFf);
    check_idle("mul_ff");
    full_op("mulh_ffff", MD_MULH, 16'hFFFF, 16'hFFFF, 4'd4, 16'hFFFE, LatFfff);
    full_op("mul_ffff", MD_MUL, 16'hFFFF, 16'hFFFF, 4'd4, 16'h0001, LatFfff);
    full_op("divu_1000_7", MD_DIVU, 16'd1000, 16'd7, 4'd7, 16'd142, 17);
    full_op("remu_1000_7", MD_REMU, 16'd1000, 16'd7, 4'd8, 16'd6, 17);
    full_op("divu_5_0", MD_DIVU, 16'd5, 16'd0, 4'd1, 16'hFFFF, 1);
    check_idle("divu_5_0");
    full_op("remu_5_0", MD_REMU, 16'd5, 16'd0, 4'd2, 16'd5, 1);
    full_op("mul_rd0", MD_MUL, 16'd2, 16'd3, 4'd0, 16'd6, Lat2x3);
    full_op("mul_9x1", MD_MUL, 16'd9, 16'd1, 4'd10, 16'd9, Lat9x1);

    // Flush at cycle 8 with a simultaneous start: both the op and the start are dropped.
    launch(MD_MUL, 16'h1234, 16'hFFFF, 4'd5);
    repeat (7) @(negedge clk);
    check("flush_pre_status", alu_status, ST_BUSY_MUL);
    flush = 1'b1; start = 1'b1; op = MD_DIVU; src_b = 16'd3; rd_in = 4'd12;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    check("flush_status", alu_status, ST_IDLE);
    check("flush_busy_rd", busy_rd, 0);
    bad = 0;
    repeat (20) begin
      if (result_valid !== 1'b0 || alu_status !== ST_IDLE) bad++;
      @(negedge clk);
    end
    check("flush_no_writeback", bad, 0);

    // Back-to-back: DIVU issued in the DONE cycle of a MUL.
    full_op("b2b_mul", MD_MUL, 16'd3, 16'd4, 4'd2, 16'd12, Lat3x4);
    op = MD_DIVU; src_a = 16'd100; src_b = 16'd10; rd_in = 4'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_div_status", alu_status, ST_BUSY_DIV);
    check("b2b_div_busy_rd", busy_rd, 6);
    run_to_done("b2b_div", ST_BUSY_DIV, lat);
    check("b2b_div_latency", lat, 17);
    check("b2b_div_result", result, 10);
    check("b2b_div_result_rd", result_rd, 6);

    // Asynchronous reset in the middle of a divide.
    launch(MD_DIVU, 16'd1000, 16'd7, 4'd9);
    repeat (5) @(negedge clk);
    check("rst_mid_pre_status", alu_status, ST_BUSY_DIV);
    rst_n = 1'b0;
    #1;
    check("rst_mid_status", alu_status, ST_IDLE);
    check("rst_mid_busy_rd", busy_rd, 0);
    check("rst_mid_valid", result_valid, 0);
    check("rst_mid_result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check_idle("rst_mid");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Controller and datapath for the shared iterative multiply/divide unit in the EX stage of the 16-bit pipeline.
- Accepts one operation at a time and sequences the shift-add multiply or restoring divide, one bit per cycle.
- Drives the 2-bit alu_status consumed by the hazard controller, which stalls IF/ID and ID/EX while alu_status > 2'b01.
- Presents the result and destination register for writeback.

Parameters:
- WIDTH, 16, operand and result width in bits.
- RD_W, 4, destination register index width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  launch operation; sampled only in IDLE or DONE
- op  in  2  00 MUL (low half), 01 MULH (high half, unsigned), 10 DIVU (quotient), 11 REMU (remainder)
- src_a  in  WIDTH  multiplicand / dividend
- src_b  in  WIDTH  multiplier / divisor
- rd_in  in  RD_W  destination register
- flush  in  1  abort the in-flight operation (branch/exception kill)
- result  out  WIDTH  final result; valid while result_valid=1
- result_valid  out  1  single-cycle writeback strobe
- result_rd  out  RD_W  destination for result; 0 when idle
- busy_rd  out  RD_W  destination of the in-flight op, 0 when none (for register-hazard compare)
- alu_status  out  2  00 idle, 01 result this cycle, 10 busy MUL/MULH, 11 busy DIVU/REMU

Behaviour:
- Reset: asynchronous on rst_n low; state=IDLE. result=0, result_valid=0, result_rd=0, busy_rd=0, alu_status=00. All internal registers are cleared.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE/DONE + start: latch op, operands, and rd_in; clear the bit counter.
  - op[1]=0: go to MUL.
  - op[1]=1 and src_b≠0: go to DIV.
  - op[1]=1 and src_b=0: go directly to DONE with the div-by-zero result.
- IDLE/DONE, no start: go to IDLE.
- MUL: per cycle, if multiplier LSB=1, add the multiplicand into the upper half of the 2·WIDTH accumulator, then shift right one. Stay in MUL for exactly WIDTH cycles, then go to DONE.
- DIV: restoring algorithm, one quotient bit per cycle (shift the remainder, trial-subtract, keep if non-negative). Stay in DIV for exactly WIDTH cycles, then go to DONE.
- DONE: result_valid=1 and alu_status=01 for exactly one cycle. result_rd equals the latched rd.
  - MUL returns acc[WIDTH-1:0]; MULH returns acc[2·WIDTH-1:WIDTH].
  - DIVU returns the quotient; REMU returns the remainder.
- Latency from the start cycle to the result_valid cycle:
  - WIDTH+1 cycles for MUL/DIV (17 at default).
  - 1 cycle for div-by-zero.
- Div-by-zero results: DIVU returns all ones (16'hFFFF); REMU returns src_a.
- alu_status: 10 in MUL, 11 in DIV, 01 in DONE, 00 in IDLE.
- busy_rd = latched rd in MUL, DIV, and DONE; 0 otherwise.
- start while in MUL or DIV: ignored. The issuing stage is stalled by alu_status, so this is a protocol violation with no effect.
- start in DONE: accepted back-to-back. The current result is still delivered that cycle, and the new op enters MUL/DIV next cycle.
- flush: synchronous. MUL/DIV/DONE go to IDLE next cycle; result_valid is forced 0 in the flush cycle; no result is written back.
  - flush and start together: flush wins, and start is dropped.
- rd_in=0 is legal. The op runs and result_rd=0, and writeback ignores it.
- Reset mid-operation: immediately returns to IDLE with all outputs at their reset values; the partial result is discarded.

Optional Feature:
- MULDIV_EARLY_OUT_EN, defined: in MUL, once the remaining multiplier bits are all zero, the FSM goes to DONE on the next cycle. The accumulator is aligned by shifting right by the remaining count in that cycle.
  - Minimum MUL latency is 2 cycles, e.g. src_b=1 gives result_valid on the 2nd cycle after start.
  - DIV latency is unchanged.
- MULDIV_EARLY_OUT_EN, undefined: fixed WIDTH+1 MUL latency.
- Results are bit-identical in both builds.

Decomposition:
- Shared package (cpu_pkg), new contents:
  - op encodings MD_MUL, MD_MULH, MD_DIVU, MD_REMU.
  - alu_status encodings ST_IDLE, ST_DONE, ST_BUSY_MUL, ST_BUSY_DIV.
  - The FSM state enum.
- Shared package, existing contents: WIDTH/RD_W defaults, which are the same as the register file.
- One natural sub-module: muldiv_step.
  - Combinational single-iteration add/shift and trial-subtract/shift.
  - Selected by op[1].
  - Instanced once; the FSM stays in the parent.

Test Plan:
- MUL 16'h00FF×16'h0101 with rd=3 -> alu_status=10 for 16 cycles, then one cycle of result=16'hFFFF, result_valid=1, result_rd=3, alu_status=01, then 00.
- MULH 16'hFFFF×16'hFFFF -> result=16'hFFFE at cycle 17; a repeat with MUL gives 16'h0001.
- DIVU 1000/7 -> alu_status=11 for 16 cycles, result=142; REMU 1000/7 -> result=6.
- DIVU 5/0 -> result=16'hFFFF on the cycle after start; REMU 5/0 -> result=5; no busy state.
- MUL launched and flushed at cycle 8 -> alu_status=00 and busy_rd=0 next cycle; result_valid never asserts. start asserted together with flush -> dropped.
- Back-to-back: start DIVU in the DONE cycle of a MUL -> MUL result delivered, alu_status=11 next cycle. rst_n pulsed low mid-DIV -> all outputs 0 immediately. With MULDIV_EARLY_OUT_EN, 9×1 -> result=9 at cycle 2.
